// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and helpers for the stream demultiplexer.
//   state_t    : packet-tracking FSM states (IDLE = no packet open, PKT = open)
//   clog2_min1 : ceil(log2(n)) with a floor of 1, used to size the select field
package stream_demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_reg.sv
// stream_reg: one-entry valid/ready pipeline register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_valid, i_data   : upstream beat
//   o_ready           : upstream may transfer (register empty or draining now)
//   o_valid, o_data   : registered beat towards the consumer
//   i_ready           : consumer accepts the registered beat
// A full register that drains can take a new beat in the same cycle.
module stream_reg #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [PW-1:0] i_data,
  output logic          o_ready,
  output logic          o_valid,
  output logic [PW-1:0] o_data,
  input  logic          i_ready
);

  logic          r_valid;
  logic [PW-1:0] r_data;
  logic          w_ready;

  assign w_ready = ~r_valid | i_ready;
  assign o_ready = w_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_valid && w_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1-to-N_OUT valid/ready stream demultiplexer with one register stage.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_data/in_sel/in_last/in_valid/in_ready : shared input stream; in_sel is
//                        sampled on the first beat of each packet only
//   out_data           : N_OUT copies of the registered payload, channel k at [k*W +: W]
//   out_last/out_valid : per-channel flags, at most one channel active
//   out_ready          : per-channel consumer ready; only the addressed bit matters
//   busy               : a packet is open
//   err_sel            : sticky, a packet started with in_sel >= N_OUT
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int unsigned N_OUT = 2,
  parameter  int unsigned W     = 8,
  localparam int unsigned SEL_W = clog2_min1(N_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W-1:0]       in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N_OUT*W-1:0] out_data,
  output logic [N_OUT-1:0]   out_last,
  output logic [N_OUT-1:0]   out_valid,
  input  logic [N_OUT-1:0]   out_ready,
  output logic               busy,
  output logic               err_sel
);

  localparam int unsigned PW = W + 1 + SEL_W;

  state_t           r_state;
  state_t           w_state_next;
  logic [SEL_W-1:0] r_cur_dest;
  logic             r_drop;
  logic             r_err;

  logic             w_acc;
  logic             w_bad_sel;
  logic             w_drop_beat;
  logic             w_load;
  logic             w_s_ready;
  logic             w_m_ready;
  logic             w_reg_valid;
  logic             w_reg_last;
  logic [SEL_W-1:0] w_dest;
  logic [SEL_W-1:0] w_reg_dest;
  logic [W-1:0]     w_reg_data;
  logic [PW-1:0]    w_pay_in;
  logic [PW-1:0]    w_pay_out;

  assign w_bad_sel   = (32'(in_sel) >= N_OUT);
  assign w_dest      = (r_state == IDLE) ? in_sel : r_cur_dest;
  assign w_drop_beat = (r_state == IDLE) ? w_bad_sel : r_drop;
  assign w_acc       = in_valid & w_s_ready;
  // Dropped beats still handshake upstream; they just never enter the register.
  assign w_load      = in_valid & ~w_drop_beat;
  assign w_pay_in    = {in_data, in_last, w_dest};

  assign {w_reg_data, w_reg_last, w_reg_dest} = w_pay_out;

  stream_reg #(.PW(PW)) u_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_load),
    .i_data  (w_pay_in),
    .o_ready (w_s_ready),
    .o_valid (w_reg_valid),
    .o_data  (w_pay_out),
    .i_ready (w_m_ready)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_acc && !in_last) w_state_next = PKT;
      PKT:     if (w_acc && in_last)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cur_dest <= '0;
      r_drop     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_acc && (r_state == IDLE)) begin
        r_cur_dest <= in_sel;
        r_drop     <= w_bad_sel & ~in_last;
        if (w_bad_sel) r_err <= 1'b1;
      end else if (w_acc && in_last) begin
        r_drop <= 1'b0;
      end
    end
  end

  always_comb begin
    w_m_ready = 1'b0;
    out_valid = '0;
    out_last  = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (32'(w_reg_dest) == k) begin
        out_valid[k] = w_reg_valid;
        out_last[k]  = w_reg_valid & w_reg_last;
        w_m_ready    = out_ready[k];
      end
    end
  end

  assign out_data = {N_OUT{w_reg_data}};
  assign in_ready = w_s_ready;
  assign busy     = (r_state == PKT);
  assign err_sel  = r_err;

endmodule
